// File: rtl/button_conditioner_if.sv
`default_nettype none
// ============================================================================
// Module   : button_conditioner_if
// Brief    : Button-side signal bundle between pin logic and the conditioner.
// Revision : 1.0 - initial release
// ============================================================================
interface button_conditioner_if #(
    parameter int N_BUTTONS = 2
);
    logic                 en;
    logic [N_BUTTONS-1:0] btn_in;
    logic [N_BUTTONS-1:0] btn_level;
    logic [N_BUTTONS-1:0] btn_pulse;
    logic [N_BUTTONS-1:0] btn_repeating;

    modport master (
        output en,
        output btn_in,
        input  btn_level,
        input  btn_pulse,
        input  btn_repeating
    );

    modport slave (
        input  en,
        input  btn_in,
        output btn_level,
        output btn_pulse,
        output btn_repeating
    );
endinterface
`default_nettype wire

// File: rtl/button_conditioner.sv
`default_nettype none
// ============================================================================
// Module   : button_conditioner
// Brief    : Per-button synchronizer, debounce, press pulse and auto-repeat.
// Revision : 1.0 - initial release
// ============================================================================
module button_conditioner #(
    parameter int N_BUTTONS       = 2,
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int HOLD_CYCLES     = 5000000,
    parameter int REPEAT_CYCLES   = 2000000
) (
    input  wire logic           clk,
    input  wire logic           rst,
    button_conditioner_if.slave bus
);

    localparam int DB_W   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int HOLD_W = $clog2(HOLD_CYCLES + 1);
    localparam int REP_W  = $clog2(REPEAT_CYCLES + 1);

    localparam logic [DB_W-1:0]   c_DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [HOLD_W-1:0] c_HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
    localparam logic [REP_W-1:0]  c_REP_LAST  = REP_W'(REPEAT_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_HELD   = 2'd1,
        S_REPEAT = 2'd2
    } state_t;

    logic [N_BUTTONS-1:0] w_level_vec;
    logic [N_BUTTONS-1:0] w_pulse_vec;
    logic [N_BUTTONS-1:0] w_repeating_vec;

    for (genvar g = 0; g < N_BUTTONS; g++) begin : g_ch
        logic              r_sync1;
        logic              r_sync2;
        logic              r_level;
        logic [DB_W-1:0]   r_db_cnt;
        logic              w_level_nxt;
        logic [DB_W-1:0]   w_db_cnt_nxt;
        state_t            r_state;
        state_t            w_state_nxt;
        logic [HOLD_W-1:0] r_hold_cnt;
        logic [HOLD_W-1:0] w_hold_cnt_nxt;
        logic [REP_W-1:0]  r_rep_cnt;
        logic [REP_W-1:0]  w_rep_cnt_nxt;
        logic              w_pulse_nxt;
        logic              r_pulse;
        logic              r_repeating;

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_sync1 <= 1'b0;
                r_sync2 <= 1'b0;
            end else begin
                r_sync1 <= bus.btn_in[g];
                r_sync2 <= r_sync1;
            end
        end

        // The accepted level is computed one step ahead so the press pulse
        // can be registered on the same edge that the level itself flips.
        always_comb begin
            w_level_nxt  = r_level;
            w_db_cnt_nxt = '0;
            if (r_sync2 != r_level) begin
                if (r_db_cnt >= c_DB_LAST) begin
                    w_level_nxt = ~r_level;
                end else begin
                    w_db_cnt_nxt = r_db_cnt + DB_W'(1);
                end
            end
        end

        always_comb begin
            w_state_nxt    = r_state;
            w_hold_cnt_nxt = r_hold_cnt;
            w_rep_cnt_nxt  = r_rep_cnt;
            w_pulse_nxt    = 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_level_nxt && !r_level) begin
                        w_state_nxt    = S_HELD;
                        w_hold_cnt_nxt = '0;
                        w_pulse_nxt    = 1'b1;
                    end
                end
                S_HELD: begin
                    if (!w_level_nxt) begin
                        w_state_nxt    = S_IDLE;
                        w_hold_cnt_nxt = '0;
                    end else if (r_hold_cnt >= c_HOLD_LAST) begin
                        w_state_nxt    = S_REPEAT;
                        w_hold_cnt_nxt = '0;
                        w_rep_cnt_nxt  = '0;
                        w_pulse_nxt    = 1'b1;
                    end else begin
                        w_hold_cnt_nxt = r_hold_cnt + HOLD_W'(1);
                    end
                end
                S_REPEAT: begin
                    // A release landing on a due repeat wins: no pulse.
                    if (!w_level_nxt) begin
                        w_state_nxt   = S_IDLE;
                        w_rep_cnt_nxt = '0;
                    end else if (r_rep_cnt >= c_REP_LAST) begin
                        w_rep_cnt_nxt = '0;
                        w_pulse_nxt   = 1'b1;
                    end else begin
                        w_rep_cnt_nxt = r_rep_cnt + REP_W'(1);
                    end
                end
                default: begin
                    w_state_nxt    = S_IDLE;
                    w_hold_cnt_nxt = '0;
                    w_rep_cnt_nxt  = '0;
                end
            endcase
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_level     <= 1'b0;
                r_db_cnt    <= '0;
                r_state     <= S_IDLE;
                r_hold_cnt  <= '0;
                r_rep_cnt   <= '0;
                r_pulse     <= 1'b0;
                r_repeating <= 1'b0;
            end else begin
                r_level     <= w_level_nxt;
                r_db_cnt    <= w_db_cnt_nxt;
                r_state     <= w_state_nxt;
                r_hold_cnt  <= w_hold_cnt_nxt;
                r_rep_cnt   <= w_rep_cnt_nxt;
                r_pulse     <= w_pulse_nxt & bus.en;
                r_repeating <= (w_state_nxt == S_REPEAT);
            end
        end

        assign w_level_vec[g]     = r_level;
        assign w_pulse_vec[g]     = r_pulse;
        assign w_repeating_vec[g] = r_repeating;
    end

    assign bus.btn_level     = w_level_vec;
    assign bus.btn_pulse     = w_pulse_vec;
    assign bus.btn_repeating = w_repeating_vec;

endmodule
`default_nettype wire

// File: tb/tb_button_conditioner.sv
`default_nettype none
// ============================================================================
// Module   : tb_button_conditioner
// Brief    : Directed scenarios plus randomized traffic against a timing model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_button_conditioner;
    localparam int N    = 2;
    localparam int D    = 4;
    localparam int HOLD = 10;
    localparam int REP  = 3;

    logic clk = 1'b0;
    logic rst;
    int   n_tests = 0;
    int   n_fail  = 0;

    button_conditioner_if #(.N_BUTTONS(N)) bus ();

    button_conditioner #(
        .N_BUTTONS      (N),
        .DEBOUNCE_CYCLES(D),
        .HOLD_CYCLES    (HOLD),
        .REPEAT_CYCLES  (REP)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    // Reference model: inputs reach the filter two edges late; a level is
    // accepted after D consecutive disagreeing edges; pulses fall at
    // press time T, T+HOLD, T+HOLD+k*REP while the level stays high.
    logic [N-1:0] m_hist[$];
    int           m_run[N];
    int           m_press[N];
    int           m_cyc;
    logic [N-1:0] m_lvl, m_pul, m_rep;

    function automatic void model_reset();
        m_hist.delete();
        for (int c = 0; c < N; c++) begin
            m_run[c]   = 0;
            m_press[c] = -1;
        end
        m_cyc = 0;
        m_lvl = '0;
        m_pul = '0;
        m_rep = '0;
    endfunction

    function automatic void model_edge();
        logic [N-1:0] s2;
        logic         old;
        int           dt;
        s2 = '0;
        if (m_hist.size() >= 2) s2 = m_hist[m_hist.size()-2];
        m_hist.push_back(bus.btn_in);
        if (m_hist.size() > 3) void'(m_hist.pop_front());
        m_cyc++;
        for (int c = 0; c < N; c++) begin
            old = m_lvl[c];
            if (s2[c] != m_lvl[c]) begin
                m_run[c]++;
                if (m_run[c] == D) begin
                    m_lvl[c] = ~m_lvl[c];
                    m_run[c] = 0;
                end
            end else begin
                m_run[c] = 0;
            end
            m_pul[c] = 1'b0;
            m_rep[c] = 1'b0;
            if (m_lvl[c] && !old) begin
                m_press[c] = m_cyc;
                m_pul[c]   = bus.en;
            end else if (m_lvl[c]) begin
                dt       = m_cyc - m_press[c];
                m_rep[c] = (dt >= HOLD);
                m_pul[c] = bus.en && (dt >= HOLD) && (((dt - HOLD) % REP) == 0);
            end else begin
                m_press[c] = -1;
            end
        end
    endfunction

    task automatic tick();
        @(posedge clk);
        if (rst) model_reset();
        else model_edge();
        #1;
    endtask

    task automatic go_idle();
        bus.btn_in = '0;
        bus.en     = 1'b1;
        repeat (12) tick();
    endtask

    task automatic test_reset();
        rst        = 1'b1;
        bus.en     = 1'b1;
        bus.btn_in = '1;
        model_reset();
        #1;
        for (int k = 0; k < 3; k++) begin
            if (k > 0) tick();
            n_tests++;
            if (bus.btn_level !== '0 || bus.btn_pulse !== '0 || bus.btn_repeating !== '0) begin
                n_fail++;
                $display("FAIL reset k=%0d level=%b pulse=%b rep=%b (required all 0)",
                         k, bus.btn_level, bus.btn_pulse, bus.btn_repeating);
            end
        end
        bus.btn_in = '0;
        #2 rst = 1'b0;
    endtask

    task automatic test_clean_press();
        logic [N-1:0] ep, el, er;
        bus.btn_in = 2'b01;
        for (int k = 1; k <= 20; k++) begin
            tick();
            ep = {1'b0, (k == 6 || k == 16 || k == 19)};
            el = {1'b0, (k >= 6)};
            er = {1'b0, (k >= 16)};
            n_tests++;
            if (bus.btn_pulse !== ep || bus.btn_level !== el || bus.btn_repeating !== er) begin
                n_fail++;
                $display("FAIL clean_press k=%0d pulse=%b/%b level=%b/%b rep=%b/%b (got/required)",
                         k, bus.btn_pulse, ep, bus.btn_level, el, bus.btn_repeating, er);
            end
        end
        bus.btn_in = 2'b00;
        for (int j = 1; j <= 8; j++) begin
            tick();
            ep = {1'b0, (j == 2 || j == 5)};
            el = {1'b0, (j < 6)};
            er = {1'b0, (j < 6)};
            n_tests++;
            if (bus.btn_pulse !== ep || bus.btn_level !== el || bus.btn_repeating !== er) begin
                n_fail++;
                $display("FAIL clean_release j=%0d pulse=%b/%b level=%b/%b rep=%b/%b (got/required)",
                         j, bus.btn_pulse, ep, bus.btn_level, el, bus.btn_repeating, er);
            end
        end
        go_idle();
    endtask

    task automatic test_bounce();
        int n_pulse;
        n_pulse = 0;
        for (int p = 0; p < 4; p++) begin
            bus.btn_in = (p % 2 == 0) ? 2'b10 : 2'b00;
            repeat (2) begin
                tick();
                if (bus.btn_pulse[1]) n_pulse++;
            end
        end
        bus.btn_in = 2'b10;
        for (int k = 1; k <= 12; k++) begin
            tick();
            if (bus.btn_pulse[1]) n_pulse++;
            n_tests++;
            if (bus.btn_pulse !== {(k == 6), 1'b0} || bus.btn_level !== {(k >= 6), 1'b0}) begin
                n_fail++;
                $display("FAIL bounce k=%0d pulse=%b level=%b (required pulse=%b level=%b)",
                         k, bus.btn_pulse, bus.btn_level, {(k == 6), 1'b0}, {(k >= 6), 1'b0});
            end
        end
        n_tests++;
        if (n_pulse !== 1) begin
            n_fail++;
            $display("FAIL bounce_count pulses=%0d required=1", n_pulse);
        end
        go_idle();
    endtask

    task automatic test_simultaneous();
        logic [N-1:0] ep;
        bus.btn_in = 2'b11;
        for (int k = 1; k <= 20; k++) begin
            tick();
            ep = (k == 6 || k == 16 || k == 19) ? 2'b11 : 2'b00;
            n_tests++;
            if (bus.btn_pulse !== ep || bus.btn_repeating !== ((k >= 16) ? 2'b11 : 2'b00)) begin
                n_fail++;
                $display("FAIL simultaneous k=%0d pulse=%b/%b rep=%b (got/required)",
                         k, bus.btn_pulse, ep, bus.btn_repeating);
            end
        end
        go_idle();
    endtask

    task automatic test_release_at_repeat();
        logic [N-1:0] ep, el, er;
        bus.btn_in = 2'b01;
        for (int k = 1; k <= 26; k++) begin
            tick();
            if (k == 16) bus.btn_in = 2'b00;
            ep = {1'b0, (k == 6 || k == 16 || k == 19)};
            el = {1'b0, (k >= 6 && k < 22)};
            er = {1'b0, (k >= 16 && k < 22)};
            n_tests++;
            if (bus.btn_pulse !== ep || bus.btn_level !== el || bus.btn_repeating !== er) begin
                n_fail++;
                $display("FAIL release_at_repeat k=%0d pulse=%b/%b level=%b/%b rep=%b/%b (got/required)",
                         k, bus.btn_pulse, ep, bus.btn_level, el, bus.btn_repeating, er);
            end
        end
        go_idle();
    endtask

    task automatic test_en_gating();
        logic [N-1:0] ep;
        bus.en     = 1'b0;
        bus.btn_in = 2'b01;
        for (int k = 1; k <= 20; k++) begin
            tick();
            if (k == 10) bus.en = 1'b1;
            ep = {1'b0, (k == 16 || k == 19)};
            n_tests++;
            if (bus.btn_pulse !== ep || bus.btn_level !== {1'b0, (k >= 6)}
                || bus.btn_repeating !== {1'b0, (k >= 16)}) begin
                n_fail++;
                $display("FAIL en_gating k=%0d pulse=%b/%b level=%b rep=%b (got/required)",
                         k, bus.btn_pulse, ep, bus.btn_level, bus.btn_repeating);
            end
        end
        go_idle();
    endtask

    task automatic test_reset_mid_hold();
        bus.btn_in = 2'b01;
        repeat (18) tick();
        n_tests++;
        if (bus.btn_repeating !== 2'b01) begin
            n_fail++;
            $display("FAIL pre_reset_repeat rep=%b required=01", bus.btn_repeating);
        end
        #2 rst = 1'b1;
        model_reset();
        #1;
        n_tests++;
        if (bus.btn_level !== '0 || bus.btn_pulse !== '0 || bus.btn_repeating !== '0) begin
            n_fail++;
            $display("FAIL async_reset level=%b pulse=%b rep=%b (required all 0)",
                     bus.btn_level, bus.btn_pulse, bus.btn_repeating);
        end
        repeat (2) tick();
        #2 rst = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            tick();
            n_tests++;
            if (bus.btn_pulse !== {1'b0, (k == 6)} || bus.btn_level !== {1'b0, (k >= 6)}) begin
                n_fail++;
                $display("FAIL reset_repress k=%0d pulse=%b level=%b (required pulse=%b level=%b)",
                         k, bus.btn_pulse, bus.btn_level, {1'b0, (k == 6)}, {1'b0, (k >= 6)});
            end
        end
        go_idle();
    endtask

    task automatic test_random();
        int left[N];
        for (int c = 0; c < N; c++) left[c] = 0;
        for (int k = 0; k < 500; k++) begin
            for (int c = 0; c < N; c++) begin
                if (left[c] == 0) begin
                    bus.btn_in[c] = ($urandom_range(0, 1) == 1);
                    left[c] = ($urandom_range(0, 3) == 0) ? $urandom_range(15, 30)
                                                          : $urandom_range(1, 8);
                end
                left[c]--;
            end
            bus.en = ($urandom_range(0, 9) != 0);
            tick();
            n_tests++;
            if (bus.btn_level !== m_lvl || bus.btn_pulse !== m_pul || bus.btn_repeating !== m_rep) begin
                n_fail++;
                $display("FAIL random k=%0d level=%b/%b pulse=%b/%b rep=%b/%b (got/required)",
                         k, bus.btn_level, m_lvl, bus.btn_pulse, m_pul, bus.btn_repeating, m_rep);
            end
        end
        go_idle();
    endtask

    initial begin
        test_reset();
        go_idle();
        test_clean_press();
        test_bounce();
        test_simultaneous();
        test_release_at_repeat();
        test_en_gating();
        test_reset_mid_hold();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
